// File: rtl/count_period.sv
// count_period: counting phase of the symbol-counting game: seconds countdown, press tally,
// seconds-remaining display. Define COUNT_DEBOUNCE_EN to debounce the press input.
module count_period #(
  parameter int unsigned COUNT_SECONDS   = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       Clk100M,
  input  logic       Rst,
  input  logic       Clk1Hz,
  input  logic       startSig,
  input  logic       btnInc,
  input  logic       stopCount,
  output logic       answerSig,
  output logic [7:0] userCount,
  output logic       counting,
  output logic [7:0] timeSeg0,
  output logic [7:0] timeSeg1
);

  typedef enum logic [1:0] {StIdle, StCount, StFire, StHold} stateT;

  localparam logic [6:0] SecInit = 7'(COUNT_SECONDS);

  stateT      stateQ, stateD;
  logic [1:0] syncQ;
  logic       acceptLvl;
  logic       prevQ, pressQ;
  logic [6:0] secLeftQ, secLeftD;
  logic [7:0] userCountD;
  logic       answerD, countingD;
  logic [6:0] tens, ones;

  // Input path: 2-flop synchronizer, optional debouncer, rising-edge detector.
  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[0], btnInc};
    end
  end

`ifdef COUNT_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DbW-1:0] dbCntQ;
  logic           acceptQ;

  // The accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      dbCntQ  <= '0;
      acceptQ <= 1'b0;
    end else if (syncQ[1] == acceptQ) begin
      dbCntQ <= '0;
    end else if (dbCntQ == DbW'(DEBOUNCE_CYCLES - 1)) begin
      dbCntQ  <= '0;
      acceptQ <= syncQ[1];
    end else begin
      dbCntQ <= dbCntQ + 1'b1;
    end
  end

  assign acceptLvl = acceptQ;
`else
  assign acceptLvl = syncQ[1];
`endif

  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      prevQ  <= 1'b0;
      pressQ <= 1'b0;
    end else begin
      prevQ  <= acceptLvl;
      pressQ <= acceptLvl & ~prevQ;
    end
  end

  // FSM: state register.
  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM: next state. Stop takes priority over a coincident tick.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (startSig) stateD = StCount;
      StCount: begin
        if (stopCount || (Clk1Hz && secLeftQ <= 7'd1)) stateD = StFire;
      end
      StFire:  stateD = StHold;
      StHold:  if (startSig) stateD = StCount;
      default: stateD = StIdle;
    endcase
  end

  // FSM: outputs, registered below.
  always_comb begin
    answerD   = (stateQ == StFire);
    countingD = (stateQ == StCount);
  end

  // Datapath next state: tally and seconds remaining.
  always_comb begin
    secLeftD   = secLeftQ;
    userCountD = userCount;
    unique case (stateQ)
      StIdle, StHold: begin
        if (startSig) begin
          secLeftD   = SecInit;
          userCountD = '0;
        end
      end
      StCount: begin
        if (pressQ && userCount != 8'hFF) userCountD = userCount + 8'd1;
        if (Clk1Hz && !stopCount) secLeftD = (secLeftQ > 7'd1) ? secLeftQ - 7'd1 : 7'd0;
      end
      default: ;
    endcase
  end

  function automatic logic [7:0] digitSeg(input logic [6:0] d);
    logic [7:0] seg;
    case (d)
      7'd0:    seg = 8'hC0;
      7'd1:    seg = 8'hF9;
      7'd2:    seg = 8'hA4;
      7'd3:    seg = 8'hB0;
      7'd4:    seg = 8'h99;
      7'd5:    seg = 8'h92;
      7'd6:    seg = 8'h82;
      7'd7:    seg = 8'hF8;
      7'd8:    seg = 8'h80;
      7'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  assign tens = secLeftQ / 7'd10;
  assign ones = secLeftQ % 7'd10;

  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      secLeftQ  <= SecInit;
      userCount <= '0;
      answerSig <= 1'b0;
      counting  <= 1'b0;
      timeSeg0  <= 8'hFF;
      timeSeg1  <= 8'hFF;
    end else begin
      secLeftQ  <= secLeftD;
      userCount <= userCountD;
      answerSig <= answerD;
      counting  <= countingD;
      timeSeg0  <= digitSeg(ones);
      timeSeg1  <= (tens == 7'd0) ? 8'hFF : digitSeg(tens);
    end
  end

endmodule
